// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor for one level of the HLS dataflow debug tree: a blocked-but-not-idle
// condition must persist for a programmable number of cycles before block is raised.
module hls_deadlock_persist_monitor #(
    parameter int NUM_AXIS = 7,
    parameter int NUM_INST = 7,
    parameter int NUM_SUB  = 1,
    parameter int THRESH_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_SUB-1:0]  sub_block_sigs,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                sticky_en,
    input  logic                clear,
    output logic                block,
    output logic [NUM_AXIS-1:0] block_src,
    output logic [NUM_SUB-1:0]  sub_src,
    output logic [THRESH_W-1:0] block_cycles,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [THRESH_W-1:0] cnt_q, cnt_d;
    logic [THRESH_W-1:0] thr_q, thr_d;
    logic [THRESH_W-1:0] thr_eff;
    logic [THRESH_W-1:0] cnt_inc;
    logic                cand;
    logic                enter_blocked;

    // All instances idle means the channels are merely quiescent, not deadlocked.
    assign cand    = (|axis_block_sigs || |sub_block_sigs) && !(&inst_idle_sigs);
    assign thr_eff = (threshold == '0) ? THRESH_W'(1) : threshold;
    assign cnt_inc = cnt_q + THRESH_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        thr_d         = thr_q;
        enter_blocked = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (cand) begin
                        cnt_d = THRESH_W'(1);
                        thr_d = thr_eff;
                        if (thr_eff == THRESH_W'(1)) begin
                            state_d       = ST_BLOCKED;
                            enter_blocked = 1'b1;
                        end else begin
                            state_d = ST_SUSPECT;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!cand) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == thr_q) begin
                            state_d       = ST_BLOCKED;
                            enter_blocked = 1'b1;
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (!sticky_en && !cand) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Debug capture: sources snapshot on the entry decision, duration saturates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block_src    <= '0;
            sub_src      <= '0;
            block_cycles <= '0;
        end else if (clear) begin
            block_src    <= '0;
            sub_src      <= '0;
            block_cycles <= '0;
        end else if (enter_blocked) begin
            block_src    <= axis_block_sigs;
            sub_src      <= sub_block_sigs;
            block_cycles <= '0;
        end else if (state_q == ST_BLOCKED && block_cycles != '1) begin
            block_cycles <= block_cycles + THRESH_W'(1);
        end
    end

    always_comb begin
        block     = (state_q == ST_BLOCKED);
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Bench for hls_deadlock_persist_monitor: a 16-bit and a 4-bit counter instance share
// stimulus and are compared each cycle against a run-length model of the detection rules.
module tb_hls_deadlock_persist_monitor;

    logic        clock;
    logic        reset_n;
    logic [6:0]  axis_block_sigs;
    logic [6:0]  inst_idle_sigs;
    logic [0:0]  sub_block_sigs;
    logic [15:0] threshold;
    logic        sticky_en;
    logic        clear;

    logic        blk0, blk1;
    logic [6:0]  bsrc0, bsrc1;
    logic [0:0]  ssrc0, ssrc1;
    logic [15:0] bc0;
    logic [3:0]  bc1;
    logic [1:0]  st0, st1;

    int vectors    = 0;
    int miscompares = 0;

    // Model state, index 0 = THRESH_W 16 instance, index 1 = THRESH_W 4 instance
    logic       m_blocked[2];
    int         m_run[2];
    int         m_thr[2];
    logic [6:0] m_bsrc[2];
    logic       m_ssrc[2];
    int         m_bc[2];

    hls_deadlock_persist_monitor #(.NUM_AXIS(7), .NUM_INST(7), .NUM_SUB(1), .THRESH_W(16)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .sub_block_sigs(sub_block_sigs), .threshold(threshold),
        .sticky_en(sticky_en), .clear(clear),
        .block(blk0), .block_src(bsrc0), .sub_src(ssrc0),
        .block_cycles(bc0), .state_dbg(st0)
    );

    hls_deadlock_persist_monitor #(.NUM_AXIS(7), .NUM_INST(7), .NUM_SUB(1), .THRESH_W(4)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .sub_block_sigs(sub_block_sigs), .threshold(threshold[3:0]),
        .sticky_en(sticky_en), .clear(clear),
        .block(blk1), .block_src(bsrc1), .sub_src(ssrc1),
        .block_cycles(bc1), .state_dbg(st1)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: counts consecutive candidate cycles against a latched threshold.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_blocked[i] = 1'b0;
                m_run[i]     = 0;
                m_thr[i]     = 0;
                m_bsrc[i]    = '0;
                m_ssrc[i]    = 1'b0;
                m_bc[i]      = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic c;
                int   t;
                int   bc_max;
                c      = ((axis_block_sigs != 0) || (sub_block_sigs != 0)) && (inst_idle_sigs != 7'h7F);
                t      = (i == 0) ? int'(threshold) : int'(threshold & 16'h000F);
                bc_max = (i == 0) ? 65535 : 15;
                if (t == 0) t = 1;
                if (clear) begin
                    m_blocked[i] = 1'b0;
                    m_run[i]     = 0;
                    m_bsrc[i]    = '0;
                    m_ssrc[i]    = 1'b0;
                    m_bc[i]      = 0;
                end else if (m_blocked[i]) begin
                    if (m_bc[i] < bc_max) m_bc[i] = m_bc[i] + 1;
                    if (!sticky_en && !c) begin
                        m_blocked[i] = 1'b0;
                        m_run[i]     = 0;
                    end
                end else if (c) begin
                    if (m_run[i] == 0) m_thr[i] = t;
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == m_thr[i]) begin
                        m_blocked[i] = 1'b1;
                        m_bsrc[i]    = axis_block_sigs;
                        m_ssrc[i]    = sub_block_sigs[0];
                        m_bc[i]      = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    // scoreboard helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] exp);
        chk(name, dut_v, exp);
        chk({name, " model"}, mdl_v, exp);
    endtask

    task automatic check_all();
        chk("i0 block",        32'(blk0),  32'(m_blocked[0]));
        chk("i0 block_src",    32'(bsrc0), 32'(m_bsrc[0]));
        chk("i0 sub_src",      32'(ssrc0), 32'(m_ssrc[0]));
        chk("i0 block_cycles", 32'(bc0),   32'(m_bc[0]));
        chk("i1 block",        32'(blk1),  32'(m_blocked[1]));
        chk("i1 block_src",    32'(bsrc1), 32'(m_bsrc[1]));
        chk("i1 sub_src",      32'(ssrc1), 32'(m_ssrc[1]));
        chk("i1 block_cycles", 32'(bc1),   32'(m_bc[1]));
    endtask

    // driver: apply one cycle of inputs at negedge, compare at the next negedge
    task automatic step(input logic [6:0] ax, input logic [6:0] id, input logic sb,
                        input logic [15:0] th, input logic st, input logic cl);
        axis_block_sigs = ax;
        inst_idle_sigs  = id;
        sub_block_sigs  = sb;
        threshold       = th;
        sticky_en       = st;
        clear           = cl;
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        logic       press;
        logic [6:0] ax;
        logic [6:0] id;
        logic [15:0] th;
        logic       st;

        reset_n         = 1'b0;
        axis_block_sigs = '0;
        inst_idle_sigs  = '0;
        sub_block_sigs  = '0;
        threshold       = 16'd4;
        sticky_en       = 1'b0;
        clear           = 1'b0;
        repeat (2) @(negedge clock);
        lit("reset block", 32'(blk0), 32'(m_blocked[0]), 0);
        lit("reset block_cycles", 32'(bc0), 32'(m_bc[0]), 0);
        chk("reset block_src", 32'(bsrc0), 0);
        chk("reset sub_src", 32'(ssrc0), 0);
        reset_n = 1'b1;
        @(negedge clock);
        check_all();

        // threshold 4, hold 7'h04 cycles 0-9, drop in cycle 10
        for (int k = 0; k <= 10; k++) begin
            step((k < 10) ? 7'h04 : 7'h00, 7'h00, 1'b0, 16'd4, 1'b0, 1'b0);
            if (k == 2) lit("s1 block c3", 32'(blk0), 32'(m_blocked[0]), 0);
            if (k == 3) begin
                lit("s1 block c4", 32'(blk0), 32'(m_blocked[0]), 1);
                lit("s1 block_src c4", 32'(bsrc0), 32'(m_bsrc[0]), 32'h04);
                lit("s1 block_cycles c4", 32'(bc0), 32'(m_bc[0]), 0);
            end
            if (k == 9) lit("s1 block_cycles c10", 32'(bc0), 32'(m_bc[0]), 6);
            if (k == 10) lit("s1 block c11", 32'(blk0), 32'(m_blocked[0]), 0);
        end

        // threshold 4, candidate broken in cycle 3
        step(7'h00, 7'h00, 1'b0, 16'd4, 1'b0, 1'b1);
        for (int k = 0; k <= 7; k++) begin
            step((k == 3) ? 7'h00 : 7'h10, 7'h00, 1'b0, 16'd4, 1'b0, 1'b0);
            if (k == 6) lit("s2 block c7", 32'(blk0), 32'(m_blocked[0]), 0);
            if (k == 7) lit("s2 block c8", 32'(blk0), 32'(m_blocked[0]), 1);
        end
        step(7'h00, 7'h00, 1'b0, 16'd4, 1'b0, 1'b0);

        // threshold 0 behaves as 1, single-cycle child pulse
        step(7'h00, 7'h00, 1'b0, 16'd0, 1'b0, 1'b1);
        step(7'h00, 7'h00, 1'b1, 16'd0, 1'b0, 1'b0);
        lit("s3 block c1", 32'(blk0), 32'(m_blocked[0]), 1);
        lit("s3 sub_src", 32'(ssrc0), 32'(m_ssrc[0]), 1);
        lit("s3 block_src", 32'(bsrc0), 32'(m_bsrc[0]), 0);
        step(7'h00, 7'h00, 1'b0, 16'd0, 1'b0, 1'b0);
        lit("s3 block c2", 32'(blk0), 32'(m_blocked[0]), 0);

        // sticky hold, threshold 2, clear in cycle 20
        step(7'h00, 7'h00, 1'b0, 16'd2, 1'b1, 1'b1);
        for (int k = 0; k <= 20; k++) begin
            step((k <= 3) ? 7'h01 : 7'h00, 7'h00, 1'b0, 16'd2, 1'b1, (k == 20));
            if (k == 0) lit("s4 block c1", 32'(blk0), 32'(m_blocked[0]), 0);
            if (k == 1) lit("s4 block c2", 32'(blk0), 32'(m_blocked[0]), 1);
            if (k == 19) begin
                lit("s4 block c20", 32'(blk0), 32'(m_blocked[0]), 1);
                lit("s4 block_cycles c20", 32'(bc0), 32'(m_bc[0]), 18);
            end
            if (k == 20) begin
                lit("s4 block c21", 32'(blk0), 32'(m_blocked[0]), 0);
                lit("s4 block_src c21", 32'(bsrc0), 32'(m_bsrc[0]), 0);
            end
        end

        // all instances idle masks the candidate
        for (int k = 0; k <= 8; k++) begin
            step(7'h7F, (k < 6) ? 7'h7F : 7'h7E, 1'b0, 16'd3, 1'b0, 1'b0);
            if (k == 5) lit("s5 block idle", 32'(blk0), 32'(m_blocked[0]), 0);
            if (k == 7) lit("s5 block c8", 32'(blk0), 32'(m_blocked[0]), 0);
            if (k == 8) lit("s5 block c9", 32'(blk0), 32'(m_blocked[0]), 1);
        end
        step(7'h00, 7'h00, 1'b0, 16'd3, 1'b0, 1'b1);

        // 4-bit block_cycles saturation, then asynchronous reset mid-hold
        for (int k = 0; k < 40; k++) step(7'h02, 7'h00, 1'b0, 16'd1, 1'b1, 1'b0);
        lit("s6 i0 block_cycles", 32'(bc0), 32'(m_bc[0]), 39);
        lit("s6 i1 block_cycles", 32'(bc1), 32'(m_bc[1]), 15);
        lit("s6 i1 block", 32'(blk1), 32'(m_blocked[1]), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst i0 block", 32'(blk0), 0);
        chk("async rst i1 block", 32'(blk1), 0);
        chk("async rst i0 block_src", 32'(bsrc0), 0);
        chk("async rst i0 block_cycles", 32'(bc0), 0);
        chk("async rst i1 block_cycles", 32'(bc1), 0);
        @(negedge clock);
        reset_n = 1'b1;
        check_all();

        // randomized episodes
        press = 1'b0;
        th    = 16'd3;
        st    = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) press = ~press;
            if ($urandom_range(0, 19) == 0)
                th = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(16, 21)) : 16'($urandom_range(0, 8));
            if ($urandom_range(0, 39) == 0) st = ~st;
            ax = press ? 7'($urandom_range(0, 127)) : 7'h00;
            id = ($urandom_range(0, 11) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
            step(ax, id, press && ($urandom_range(0, 3) == 0), th, st, ($urandom_range(0, 59) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
